fwd_hazard_ctrl: RTL and testbench
==================================

FWD_HAZARD_CTRL -- requirements
Module: fwd_hazard_ctrl

Interface
REQ-001 Parameter DEPTH, default 2, number of in-flight producer stages tracked for forwarding (legal 1..4).
REQ-002 Parameter LOAD_LAT, default 1, history positions after a load during which its result is not yet forwardable (legal 0..DEPTH-1).
REQ-003 Parameter CNT_W, default 32, width of the stall performance counter.
REQ-004 Derived FW = $clog2(DEPTH+1), width of each forward-select output.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 instr_valid  input  1  instr holds a real instruction in decode this cycle.
REQ-008 instr  input  32  RV32I instruction in decode.
REQ-009 flush  input  1  decode instruction is killed (taken branch/jump resolved).
REQ-010 stall  output  1  hold fetch/decode, inject bubble into EX.
REQ-011 fwd_a  output  FW  rs1 source: 0 = register file, k = history entry k-1.
REQ-012 fwd_b  output  FW  rs2 source, same encoding as fwd_a.
REQ-013 use_pc_a  output  1  ALU operand A is PC (AUIPC, JAL, branches).
REQ-014 use_imm_b  output  1  ALU operand B is immediate (all non-R opcodes).
REQ-015 stall_cnt  output  CNT_W  count of stall cycles since reset.

Function
REQ-016 Block SHALL hold a history shift register of DEPTH entries {valid, rd[4:0], is_load}; entry 0 = instruction most recently issued to EX.
REQ-017 Source usage decoded from instr[6:2]: 01100/01000/11000 use rs1 and rs2; 00000/00100/11001 use rs1 only; 01101/00101/11011 use neither.
REQ-018 Instruction writes rd iff opcode in {01100,00000,00100,11001,11011,01101,00101} and instr[11:7] != 0; is_load iff opcode 00000.
REQ-019 rs match on entry k requires entry valid, rd == rs, rs != 0, and the source used; fwd_x = (youngest matching k)+1, else 0.
REQ-020 Load-use: stall SHALL be 1 when instr_valid, !flush, and the youngest match for any used source is a load at index k < LOAD_LAT.
REQ-021 While stall=1, fwd_a and fwd_b SHALL be 0.
REQ-022 Outputs fwd_a, fwd_b, stall, use_pc_a, use_imm_b are combinational from instr and history; no added latency.
REQ-023 Each cycle history shifts by one (entry k -> k+1, oldest dropped); entry 0 loads {1, rd, is_load} when instr_valid & !stall & !flush & writes rd, else a bubble {0,0,0}.
REQ-024 A stall inserts exactly one bubble per cycle; stall repeats until the load ages past LOAD_LAT, i.e. LOAD_LAT-k cycles.
REQ-025 flush has priority over stall: flush=1 forces stall=0 and a bubble into entry 0.
REQ-026 instr_valid=0: stall=0, fwd=0, bubble shifted in.
REQ-027 stall_cnt SHALL increment by 1 each cycle stall=1 and saturate at all-ones.
REQ-028 Unknown opcodes SHALL be treated as using no sources and writing no rd.

Reset
REQ-029 rst=1 at a clock edge SHALL clear every history entry to {0,0,0} and stall_cnt to 0, overriding shift and count that cycle.
REQ-030 During and immediately after reset, stall=0 and fwd_a=fwd_b=0 for any instr.

Structure
REQ-031 Opcode constants and forward-select encoding (0 = regfile) SHALL live in the shared package rv32_pkg.
REQ-032 Opcode/source decode SHALL be a combinational sub-module rv32_src_decode (outputs uses_rs1, uses_rs2, writes_rd, is_load, use_pc_a, use_imm_b).

Verification (DEPTH=2, LOAD_LAT=1)
REQ-033 add x5,x1,x2 then add x6,x5,x3 -> second: fwd_a=1, fwd_b=0, stall=0.
REQ-034 add x5,..; addi x0,..; sub x7,x4,x5 -> sub: fwd_b=2, fwd_a=0.
REQ-035 lw x8,0(x1) then add x9,x8,x8 -> stall=1 one cycle, stall_cnt=1; next cycle fwd_a=fwd_b=2.
REQ-036 lw x8; then beq x8,x0 with flush=1 -> stall=0, no bubble count, entry 0 bubble.
REQ-037 add x0,x1,x2 then add x3,x0,x0 -> fwd_a=fwd_b=0.
REQ-038 lw x8 then rst=1 mid-stall -> next cycle stall=0, stall_cnt=0, history empty.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared RV32I opcode constants, forward-select encoding and hazard history entry type.
// Constants only; no logic or timing.
package rv32_pkg;

  // instr[6:2] opcode groups
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_OPIMM  = 5'b00100;
  localparam logic [4:0] OPC_AUIPC  = 5'b00101;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_OP     = 5'b01100;
  localparam logic [4:0] OPC_LUI    = 5'b01101;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_JALR   = 5'b11001;
  localparam logic [4:0] OPC_JAL    = 5'b11011;

  // Forward select value meaning "read the register file"; k>0 selects history entry k-1
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic       is_load;
  } hist_t;

  localparam hist_t HIST_BUBBLE = '{valid: 1'b0, rd: 5'd0, is_load: 1'b0};

endpackage

// File: rtl/rv32_src_decode.sv
// Combinational RV32I opcode decode: register sources used, rd write, load, ALU operand muxing.
// Zero latency; unknown opcodes use no sources and write nothing.
module rv32_src_decode
  import rv32_pkg::*;
(
  input  logic [4:0] opcode,
  output logic       uses_rs1,
  output logic       uses_rs2,
  output logic       writes_rd,
  output logic       is_load,
  output logic       use_pc_a,
  output logic       use_imm_b
);

  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    use_pc_a  = 1'b0;
    use_imm_b = (opcode != OPC_OP);
    unique case (opcode)
      OPC_OP: begin
        uses_rs1  = 1'b1;
        uses_rs2  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_STORE: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
        use_pc_a = 1'b1;
      end
      OPC_LOAD: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
        is_load   = 1'b1;
      end
      OPC_OPIMM, OPC_JALR: begin
        uses_rs1  = 1'b1;
        writes_rd = 1'b1;
      end
      OPC_LUI: begin
        writes_rd = 1'b1;
      end
      OPC_AUIPC, OPC_JAL: begin
        writes_rd = 1'b1;
        use_pc_a  = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Decode-stage forwarding select and load-use stall control over a DEPTH-entry producer history.
// Outputs are combinational from instr and history; history and stall counter update each rising edge.
module fwd_hazard_ctrl
  import rv32_pkg::*;
#(
  parameter  int DEPTH    = 2,
  parameter  int LOAD_LAT = 1,
  parameter  int CNT_W    = 32,
  localparam int FW       = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [31:0]      instr,
  input  logic             flush,
  output logic             stall,
  output logic [FW-1:0]    fwd_a,
  output logic [FW-1:0]    fwd_b,
  output logic             use_pc_a,
  output logic             use_imm_b,
  output logic [CNT_W-1:0] stall_cnt
);

  hist_t            hist_q [DEPTH];
  hist_t            hist_d [DEPTH];
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic          uses_rs1, uses_rs2, writes_rd, is_load;
  logic [4:0]    rs1, rs2, rd;
  logic [FW-1:0] sel_a, sel_b;
  logic          load_hit_a, load_hit_b;
  logic          issue;
  logic          unused_instr_bits;

  assign rs1 = instr[19:15];
  assign rs2 = instr[24:20];
  assign rd  = instr[11:7];
  assign unused_instr_bits = ^{instr[31:25], instr[14:12], instr[1:0]};

  rv32_src_decode u_decode (
    .opcode    (instr[6:2]),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .writes_rd (writes_rd),
    .is_load   (is_load),
    .use_pc_a  (use_pc_a),
    .use_imm_b (use_imm_b)
  );

  // Walk oldest to youngest so the youngest matching producer wins.
  always_comb begin
    sel_a      = FW'(FWD_REGFILE);
    sel_b      = FW'(FWD_REGFILE);
    load_hit_a = 1'b0;
    load_hit_b = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (uses_rs1 && rs1 != 5'd0 && hist_q[k].valid && hist_q[k].rd == rs1) begin
        sel_a      = FW'(k + 1);
        load_hit_a = hist_q[k].is_load && (k < LOAD_LAT);
      end
      if (uses_rs2 && rs2 != 5'd0 && hist_q[k].valid && hist_q[k].rd == rs2) begin
        sel_b      = FW'(k + 1);
        load_hit_b = hist_q[k].is_load && (k < LOAD_LAT);
      end
    end
  end

  assign stall = instr_valid && !flush && !rst && (load_hit_a || load_hit_b);
  assign fwd_a = (instr_valid && !rst && !stall) ? sel_a : FW'(FWD_REGFILE);
  assign fwd_b = (instr_valid && !rst && !stall) ? sel_b : FW'(FWD_REGFILE);
  assign issue = instr_valid && !stall && !flush && writes_rd;

  always_comb begin
    hist_d[0] = issue ? '{valid: 1'b1, rd: rd, is_load: is_load} : HIST_BUBBLE;
    for (int k = 1; k < DEPTH; k++) begin
      hist_d[k] = hist_q[k-1];
    end
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != {CNT_W{1'b1}}) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= HIST_BUBBLE;
      end
      stall_cnt_q <= '0;
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        hist_q[k] <= hist_d[k];
      end
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed-vector bench for fwd_hazard_ctrl (DEPTH=2, LOAD_LAT=1) plus a narrow-counter instance for saturation.
module tb_fwd_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic [31:0] instr;
  logic        flush;

  logic        stall, use_pc_a, use_imm_b;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] stall_cnt;

  logic        s_stall, s_use_pc_a, s_use_imm_b;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.DEPTH(2), .LOAD_LAT(1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .flush(flush),
    .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .use_pc_a(use_pc_a), .use_imm_b(use_imm_b), .stall_cnt(stall_cnt)
  );

  fwd_hazard_ctrl #(.DEPTH(2), .LOAD_LAT(1), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr), .flush(flush),
    .stall(s_stall), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .use_pc_a(s_use_pc_a), .use_imm_b(s_use_imm_b), .stall_cnt(s_stall_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {12'h000, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [4:0] rs1, input logic [4:0] rs2);
    return {7'h00, rs2, rs1, 3'b000, 5'h00, 7'b1100011};
  endfunction

  task automatic drive(input logic v, input logic [31:0] ins, input logic fl);
    instr_valid = v;
    instr       = ins;
    flush       = fl;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins);
    drive(1'b1, ins, 1'b0);
    tick();
  endtask

  logic [31:0] ADD_X5_X1_X2, LW_X8, ADD_X9_X8_X8, ADD_X6_X5_X5, NOP;
  logic [31:0] dec_ins [9];
  logic [1:0]  dec_exp [9];

  initial begin
    ADD_X5_X1_X2 = enc_r(7'h00, 5'd5, 5'd1, 5'd2);
    LW_X8        = enc_i(7'b0000011, 5'd8, 5'd1, 3'b010);
    ADD_X9_X8_X8 = enc_r(7'h00, 5'd9, 5'd8, 5'd8);
    ADD_X6_X5_X5 = enc_r(7'h00, 5'd6, 5'd5, 5'd5);
    NOP          = enc_i(7'b0010011, 5'd0, 5'd0, 3'b000);

    // Reset: outputs idle even with a decode instruction present
    rst = 1'b1;
    drive(1'b1, enc_r(7'h00, 5'd6, 5'd5, 5'd3), 1'b0);
    tick();
    tick();
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
    check("rst_cnt", stall_cnt, 32'd0);
    rst = 1'b0;

    // add x5,x1,x2 ; add x6,x5,x3
    issue(ADD_X5_X1_X2);
    drive(1'b1, enc_r(7'h00, 5'd6, 5'd5, 5'd3), 1'b0);
    check("raw1_fwd_a", {30'd0, fwd_a}, 32'd1);
    check("raw1_fwd_b", {30'd0, fwd_b}, 32'd0);
    check("raw1_stall", {31'd0, stall}, 32'd0);
    tick();

    // add x5 ; addi x0 ; sub x7,x4,x5
    issue(ADD_X5_X1_X2);
    issue(NOP);
    drive(1'b1, enc_r(7'h20, 5'd7, 5'd4, 5'd5), 1'b0);
    check("raw2_fwd_b", {30'd0, fwd_b}, 32'd2);
    check("raw2_fwd_a", {30'd0, fwd_a}, 32'd0);
    tick();

    // x0 never forwards
    issue(enc_r(7'h00, 5'd0, 5'd1, 5'd2));
    drive(1'b1, enc_r(7'h00, 5'd3, 5'd0, 5'd0), 1'b0);
    check("x0_fwd_a", {30'd0, fwd_a}, 32'd0);
    check("x0_fwd_b", {30'd0, fwd_b}, 32'd0);
    tick();

    // Youngest producer wins
    issue(ADD_X5_X1_X2);
    issue(enc_r(7'h00, 5'd5, 5'd2, 5'd3));
    drive(1'b1, ADD_X6_X5_X5, 1'b0);
    check("young_fwd_a", {30'd0, fwd_a}, 32'd1);
    check("young_fwd_b", {30'd0, fwd_b}, 32'd1);
    tick();

    // instr_valid=0 gates outputs and shifts a bubble; producer then ages out
    issue(ADD_X5_X1_X2);
    drive(1'b0, ADD_X6_X5_X5, 1'b0);
    check("inv_fwd_a", {30'd0, fwd_a}, 32'd0);
    check("inv_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, ADD_X6_X5_X5, 1'b0);
    check("bub_fwd_a", {30'd0, fwd_a}, 32'd2);
    check("bub_fwd_b", {30'd0, fwd_b}, 32'd2);
    drive(1'b0, ADD_X6_X5_X5, 1'b0);
    tick();
    tick();
    drive(1'b1, ADD_X6_X5_X5, 1'b0);
    check("aged_fwd_a", {30'd0, fwd_a}, 32'd0);

    // Load-use: one stall cycle, then forward from entry 1
    issue(LW_X8);
    drive(1'b1, ADD_X9_X8_X8, 1'b0);
    check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_stall_fwd_a", {30'd0, fwd_a}, 32'd0);
    check("lu_stall_fwd_b", {30'd0, fwd_b}, 32'd0);
    tick();
    check("lu_cnt", stall_cnt, 32'd1);
    check("lu_after_stall", {31'd0, stall}, 32'd0);
    check("lu_after_fwd_a", {30'd0, fwd_a}, 32'd2);
    check("lu_after_fwd_b", {30'd0, fwd_b}, 32'd2);
    tick();

    // Flush beats stall and inserts a bubble
    issue(LW_X8);
    drive(1'b1, enc_b(5'd8, 5'd0), 1'b1);
    check("fl_stall", {31'd0, stall}, 32'd0);
    tick();
    drive(1'b1, enc_r(7'h00, 5'd1, 5'd8, 5'd0), 1'b0);
    check("fl_cnt", stall_cnt, 32'd1);
    check("fl_bubble_fwd_a", {30'd0, fwd_a}, 32'd2);
    check("fl_bubble_fwd_b", {30'd0, fwd_b}, 32'd0);
    check("fl_next_stall", {31'd0, stall}, 32'd0);
    tick();

    // Operand mux decode: {use_pc_a, use_imm_b}
    dec_ins[0] = ADD_X5_X1_X2;                         dec_exp[0] = 2'b00;
    dec_ins[1] = NOP;                                  dec_exp[1] = 2'b01;
    dec_ins[2] = enc_b(5'd1, 5'd2);                    dec_exp[2] = 2'b11;
    dec_ins[3] = {20'h12345, 5'd3, 7'b0010111};        dec_exp[3] = 2'b11;
    dec_ins[4] = {20'h00100, 5'd1, 7'b1101111};        dec_exp[4] = 2'b11;
    dec_ins[5] = enc_i(7'b1100111, 5'd1, 5'd2, 3'b000); dec_exp[5] = 2'b01;
    dec_ins[6] = {20'h00001, 5'd4, 7'b0110111};        dec_exp[6] = 2'b01;
    dec_ins[7] = LW_X8;                                dec_exp[7] = 2'b01;
    dec_ins[8] = {7'h00, 5'd2, 5'd1, 3'b010, 5'h00, 7'b0100011}; dec_exp[8] = 2'b01;
    for (int i = 0; i < 9; i++) begin
      drive(1'b0, dec_ins[i], 1'b0);
      check($sformatf("dec%0d_pc_imm", i), {30'd0, use_pc_a, use_imm_b}, {30'd0, dec_exp[i]});
    end

    // Unknown opcode: no sources, no rd write
    issue(ADD_X5_X1_X2);
    drive(1'b1, {7'h00, 5'd5, 5'd5, 3'b000, 5'd5, 7'b1111111}, 1'b0);
    check("unk_fwd_a", {30'd0, fwd_a}, 32'd0);
    check("unk_fwd_b", {30'd0, fwd_b}, 32'd0);
    tick();
    drive(1'b1, enc_r(7'h00, 5'd6, 5'd5, 5'd0), 1'b0);
    check("unk_no_write", {30'd0, fwd_a}, 32'd2);
    tick();

    // Four more load-use stalls: wide counter reaches 5, 2-bit counter holds at 3
    for (int i = 0; i < 4; i++) begin
      issue(LW_X8);
      drive(1'b1, ADD_X9_X8_X8, 1'b0);
      tick();
      tick();
    end
    check("sat_cnt_wide", stall_cnt, 32'd5);
    check("sat_cnt_narrow", {30'd0, s_stall_cnt}, 32'd3);

    // Reset in the middle of a stall
    issue(LW_X8);
    drive(1'b1, ADD_X9_X8_X8, 1'b0);
    check("rstm_pre_stall", {31'd0, stall}, 32'd1);
    rst = 1'b1;
    #1;
    check("rstm_during_stall", {31'd0, stall}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rstm_stall", {31'd0, stall}, 32'd0);
    check("rstm_cnt", stall_cnt, 32'd0);
    check("rstm_cnt_narrow", {30'd0, s_stall_cnt}, 32'd0);
    check("rstm_fwd_a", {30'd0, fwd_a}, 32'd0);
    check("rstm_fwd_b", {30'd0, fwd_b}, 32'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
